// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic                 div_sel,
`endif
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_acc;
`endif

  // acc = {partial product, unconsumed multiplier} / {remainder, dividend->quotient}
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (acc_i[0]) begin
      mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    end else begin
      mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    end
    mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_i};
    // Remainder stays below the divisor, so bit WIDTH of the difference is its sign.
    if (!rem_diff[WIDTH]) begin
      div_acc = {rem_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
    if (div_sel) begin
      acc_o = div_acc;
    end else begin
      acc_o = mul_acc;
    end
`else
    acc_o = mul_acc;
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle mult/multu (and div/divu with MULDIV_DIV_EN) sequencer owning HI/LO.
// Operates on magnitudes and fixes the sign when the last iteration completes.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic               div_q, div_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  logic               op_ok;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last_step;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_sel (div_q),
`endif
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc)
  );

  // Operand magnitudes, legality and sign-corrected results
  always_comb begin
`ifdef MULDIV_DIV_EN
    op_ok = 1'b1;
`else
    op_ok = ~op[1];
`endif
    a_neg = op_is_signed(op) & a[WIDTH-1];
    b_neg = op_is_signed(op) & b[WIDTH-1];
    if (a_neg) begin
      a_mag = -a;
    end else begin
      a_mag = a;
    end
    if (b_neg) begin
      b_mag = -b;
    end else begin
      b_mag = b;
    end
    last_step = (count_q == CW'(WIDTH - 1));
    if (neg_q) begin
      prod_fix = -step_acc;
    end else begin
      prod_fix = step_acc;
    end
`ifdef MULDIV_DIV_EN
    if (neg_q) begin
      quo_fix = -step_acc[WIDTH-1:0];
    end else begin
      quo_fix = step_acc[WIDTH-1:0];
    end
    if (neg_rem_q) begin
      rem_fix = -step_acc[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix = step_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && op_ok) begin
          state_d = RUN;
          count_d = CW'(0);
          busy_d  = 1'b1;
          neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
          div_d     = op[1];
          neg_rem_d = a_neg;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
`else
          acc_d  = {{WIDTH{1'b0}}, b_mag};
          opnd_d = a_mag;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        if (last_step) begin
          state_d = FIN;
          count_d = CW'(0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
`else
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
`endif
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      // HI/LO and done are already presented; any start here is dropped
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= CW'(0);
      acc_q   <= {(2*WIDTH){1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
